dpc_badpoint_table_ctrl: RTL

- Owns the dead-pixel coordinate table that feeds the DPC kernel's bad-point comparison.
- Holds two banks (active/shadow). Software writes the shadow bank at any time and requests a commit; the block swaps banks only on a frame boundary, so a frame is never corrected with a mixed table.
- During a frame it walks the active bank in raster order and presents the next expected bad coordinate (width_bad/height_bad), advancing on each shift from the kernel.

---
 rtl/dpc_badpoint_table_ctrl_if.sv | 36 +++
 rtl/dpc_badpoint_table_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dpc_badpoint_table_ctrl_if.sv
// Configuration and bad-point presentation bus of the DPC bad-point table controller.
// The master drives software configuration and the kernel's frame/shift pulses.
// The slave, which is the table controller, returns the presented coordinate and status.
interface dpc_badpoint_table_ctrl_if #(
    parameter int CNT_WIDTH = 10,
    parameter int PTR_WIDTH = 7
);
    logic                   cfg_wen;
    logic [PTR_WIDTH-1:0]   cfg_waddr;
    logic [2*CNT_WIDTH-1:0] cfg_wdata;
    logic [PTR_WIDTH:0]     cfg_num;
    logic                   cfg_commit;
    logic                   frame_end;
    logic                   shift;
    logic [CNT_WIDTH-1:0]   width_bad;
    logic [CNT_WIDTH-1:0]   height_bad;
    logic                   bad_valid;
    logic                   active_bank;
    logic [PTR_WIDTH:0]     active_num;
    logic                   commit_pending;
    logic                   commit_done;
    logic                   wr_reject;
    logic                   shift_err;

    modport master (
        output cfg_wen, cfg_waddr, cfg_wdata, cfg_num, cfg_commit, frame_end, shift,
        input  width_bad, height_bad, bad_valid, active_bank, active_num,
               commit_pending, commit_done, wr_reject, shift_err
    );

    modport slave (
        input  cfg_wen, cfg_waddr, cfg_wdata, cfg_num, cfg_commit, frame_end, shift,
        output width_bad, height_bad, bad_valid, active_bank, active_num,
               commit_pending, commit_done, wr_reject, shift_err
    );
endinterface

// File: rtl/dpc_badpoint_table_ctrl.sv
// Double-banked dead-pixel coordinate table for the DPC kernel.
// Software fills the shadow bank and requests a commit.
// The banks swap only on frame_end, so a frame never sees a mixed table.
// The active bank is walked in raster order, one entry per kernel shift.
module dpc_badpoint_table_ctrl #(
    parameter int CNT_WIDTH  = 10,
    parameter int MAX_POINTS = 128,
    parameter int PTR_WIDTH  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    dpc_badpoint_table_ctrl_if.slave  bus
);
    localparam int                 NUM_W   = PTR_WIDTH + 1;
    localparam int                 ENT_W   = 2 * CNT_WIDTH;
    localparam logic [NUM_W-1:0]   MAX_NUM = NUM_W'(MAX_POINTS);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               swap;

    logic [ENT_W-1:0]   table_mem [2][MAX_POINTS];

    logic               active_bank_q;
    logic [NUM_W-1:0]   active_num_q;
    logic [NUM_W-1:0]   shadow_num_q;
    logic [NUM_W-1:0]   ptr_q;
    logic               bad_valid_q;
    logic [ENT_W-1:0]   bad_point_q;
    logic               commit_done_q;
    logic               wr_reject_q;
    logic               shift_err_q;

    logic               bank_next;
    logic [NUM_W-1:0]   num_next;
    logic [NUM_W-1:0]   ptr_next;
    logic               valid_next;
    logic [ENT_W-1:0]   point_next;
    logic [NUM_W-1:0]   num_clamped;

    // Commit handshake: wait in PENDING until the frame boundary, then swap banks.
    always_comb begin
        state_next = state;
        swap       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cfg_commit) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (bus.frame_end) begin
                    state_next = IDLE;
                    swap       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next walk position and the entry it selects; frame_end restarts the walk ahead of any shift.
    always_comb begin
        num_clamped = (bus.cfg_num > MAX_NUM) ? MAX_NUM : bus.cfg_num;
        bank_next   = active_bank_q ^ swap;
        num_next    = swap ? shadow_num_q : active_num_q;
        ptr_next    = ptr_q;
        if (bus.frame_end) begin
            ptr_next = '0;
        end else if (bus.shift && bad_valid_q && (ptr_q < active_num_q)) begin
            ptr_next = ptr_q + NUM_W'(1);
        end
        valid_next = (ptr_next < num_next);
        point_next = valid_next ? table_mem[bank_next][ptr_next[PTR_WIDTH-1:0]] : '1;
    end

    // Shadow-bank writes are accepted only while no commit is outstanding; storage is never reset.
    always_ff @(posedge clk) begin
        if (!reset && bus.cfg_wen && (state == IDLE)) begin
            table_mem[~active_bank_q][bus.cfg_waddr] <= bus.cfg_wdata;
        end
    end

    // Bank bookkeeping, walk pointer, registered coordinate and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_bank_q <= 1'b0;
            active_num_q  <= '0;
            shadow_num_q  <= '0;
            ptr_q         <= '0;
            bad_valid_q   <= 1'b0;
            bad_point_q   <= '1;
            commit_done_q <= 1'b0;
            wr_reject_q   <= 1'b0;
            shift_err_q   <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.cfg_commit) begin
                shadow_num_q <= num_clamped;
            end
            active_bank_q <= bank_next;
            active_num_q  <= num_next;
            ptr_q         <= ptr_next;
            bad_valid_q   <= valid_next;
            bad_point_q   <= point_next;
            commit_done_q <= swap;
            wr_reject_q   <= bus.cfg_wen && (state == PENDING);
            if (bus.shift && !bad_valid_q) begin
                shift_err_q <= 1'b1;
            end
        end
    end

    assign bus.width_bad      = bad_point_q[CNT_WIDTH-1:0];
    assign bus.height_bad     = bad_point_q[ENT_W-1:CNT_WIDTH];
    assign bus.bad_valid      = bad_valid_q;
    assign bus.active_bank    = active_bank_q;
    assign bus.active_num     = active_num_q;
    assign bus.commit_pending = (state == PENDING);
    assign bus.commit_done    = commit_done_q;
    assign bus.wr_reject      = wr_reject_q;
    assign bus.shift_err      = shift_err_q;
endmodule
